// File: rtl/frame_cfg_pkg.sv
// Shared constants and state type for the column configuration-frame writer.
// FRAME_CHECKSUM_EN adds the CHECK state used by the optional frame checksum.
package frame_cfg_pkg;

  localparam logic [3:0] OpWriteFrame = 4'hA;
  localparam int OpcodeMsb = 31;
  localparam int OpcodeLsb = 28;
  localparam int IdxMsb    = 4;
  localparam int IdxLsb    = 0;
  localparam int IdxWidth  = IdxMsb - IdxLsb + 1;

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, STROBE, HOLD} state_e;
`else
  typedef enum logic [2:0] {IDLE, LOAD, STROBE, HOLD} state_e;
`endif

endpackage

// File: rtl/frame_strobe_dec.sv
// Registered frame-index to one-hot FrameStrobe decoder; all lines low when disabled.
module frame_strobe_dec
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic [IdxWidth-1:0]        idx_i,
  output logic [MaxFramesPerCol-1:0] strobe_o
);

  logic [MaxFramesPerCol-1:0] strobe_d, strobe_q;

  always_comb begin
    strobe_d = '0;
    if (en_i) begin
      for (int i = 0; i < MaxFramesPerCol; i++) begin
        strobe_d[i] = (int'(idx_i) == i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) strobe_q <= '0;
    else         strobe_q <= strobe_d;
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/frame_write_ctrl.sv
// Column frame writer: header + NumberOfRows words -> FrameData, then one FrameStrobe pulse.
// Optional FRAME_CHECKSUM_EN: an XOR checksum word follows the rows and gates the strobe.
module frame_write_ctrl
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumberOfRows    = 16,
  parameter int StrobeWidth     = 1
) (
  input  logic                                    CLK,
  input  logic                                    resetn,
  input  logic [FrameBitsPerRow-1:0]              s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    busy,
  output logic                                    err_hdr,
  output logic [15:0]                             frames_done,
`ifdef FRAME_CHECKSUM_EN
  output logic                                    err_sum,
`endif
  input  logic                                    err_clr
);

  localparam int RowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [RowW-1:0] LastRow  = RowW'(NumberOfRows - 1);
  localparam logic [3:0]      LastStrb = 4'(StrobeWidth - 1);

  state_e                     state_q, state_d;
  logic [RowW-1:0]            row_q, row_d;
  logic [IdxWidth-1:0]        idx_q, idx_d;
  logic [3:0]                 strb_q, strb_d;
  logic [15:0]                frames_q, frames_d;
  logic                       err_hdr_q, err_hdr_d;
  logic [FrameBitsPerRow-1:0] rows_q [NumberOfRows];
  logic                       row_we, hdr_bad, hdr_ok, accept;
`ifdef FRAME_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0] sum_q, sum_d;
  logic                       err_sum_q, err_sum_d, sum_bad;
`endif

  assign accept = s_valid && s_ready;
  assign hdr_ok = (s_data[OpcodeMsb:OpcodeLsb] == OpWriteFrame) &&
                  (int'(s_data[IdxMsb:IdxLsb]) < MaxFramesPerCol);

`ifdef FRAME_CHECKSUM_EN
  assign s_ready = (state_q == IDLE) || (state_q == LOAD) || (state_q == CHECK);
`else
  assign s_ready = (state_q == IDLE) || (state_q == LOAD);
`endif

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    idx_d    = idx_q;
    strb_d   = strb_q;
    frames_d = frames_q;
    row_we   = 1'b0;
    hdr_bad  = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    sum_d    = sum_q;
    sum_bad  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hdr_ok) begin
            state_d = LOAD;
            row_d   = '0;
            idx_d   = s_data[IdxMsb:IdxLsb];
`ifdef FRAME_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else begin
            hdr_bad = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          row_we = 1'b1;
          row_d  = row_q + 1'b1;
          strb_d = '0;
`ifdef FRAME_CHECKSUM_EN
          sum_d  = sum_q ^ s_data;
          if (row_q == LastRow) state_d = CHECK;
`else
          if (row_q == LastRow) state_d = STROBE;
`endif
        end
      end
`ifdef FRAME_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (s_data == sum_q) begin
            state_d = STROBE;
          end else begin
            sum_bad = 1'b1;
            state_d = HOLD;
          end
        end
      end
`endif
      STROBE: begin
        if (strb_q == LastStrb) begin
          state_d  = HOLD;
          frames_d = frames_q + 16'd1;
        end else begin
          strb_d = strb_q + 4'd1;
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Clearing wins over a new error arriving in the same cycle.
    err_hdr_d = err_clr ? 1'b0 : (err_hdr_q | hdr_bad);
`ifdef FRAME_CHECKSUM_EN
    err_sum_d = err_clr ? 1'b0 : (err_sum_q | sum_bad);
`endif
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      row_q     <= '0;
      idx_q     <= '0;
      strb_q    <= '0;
      frames_q  <= '0;
      err_hdr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      idx_q     <= idx_d;
      strb_q    <= strb_d;
      frames_q  <= frames_d;
      err_hdr_q <= err_hdr_d;
    end
  end

`ifdef FRAME_CHECKSUM_EN
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      sum_q     <= '0;
      err_sum_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      err_sum_q <= err_sum_d;
    end
  end
  assign err_sum = err_sum_q;
`endif

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NumberOfRows; r++) rows_q[r] <= '0;
    end else if (row_we) begin
      rows_q[row_q] <= s_data;
    end
  end

  for (genvar r = 0; r < NumberOfRows; r++) begin : g_rows
    assign FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] = rows_q[r];
  end

  // Enabled from next state so the strobe rises together with the STROBE state.
  frame_strobe_dec #(
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_dec (
    .clk_i   (CLK),
    .rst_ni  (resetn),
    .en_i    (state_d == STROBE),
    .idx_i   (idx_q),
    .strobe_o(FrameStrobe)
  );

  assign busy        = (state_q != IDLE);
  assign err_hdr     = err_hdr_q;
  assign frames_done = frames_q;

endmodule
